// File: rtl/esc_pulse_generator.sv
// esc_pulse_generator: 50 Hz servo/ESC pulse stream for one motor channel.
// An 11-bit throttle command sets the pulse width for the next frame. Missing
// commands for STALE_FRAMES frames drop the output to the minimum pulse width.
module esc_pulse_generator #(
  parameter int CLK_DIV      = 50,
  parameter int MIN_TICKS    = 1000,
  parameter int RANGE_TICKS  = 1000,
  parameter int FRAME_TICKS  = 20000,
  parameter int STALE_FRAMES = 3
) (
  input  logic        clk_system,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [10:0] command,
  input  logic        command_valid,
  output logic        pwm_out,
  output logic        frame_start,
  output logic        stale
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(FRAME_TICKS);
  localparam int SW = (STALE_FRAMES > 0) ? $clog2(STALE_FRAMES + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [TW-1:0] MIN_W      = TW'(MIN_TICKS);
  localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] width_q, width_d;
  logic [SW-1:0] stale_cnt_q, stale_cnt_d;
  logic          stale_q, stale_d;
  logic          pend_flag_q, pend_flag_d;
  logic [10:0]   pend_val_q, pend_val_d;
  logic          pwm_q, pwm_d;
  logic          frame_start_q, frame_start_d;

  logic          tick;
  logic          frame_load;
  logic [31:0]   pend_ext;
  logic [31:0]   add_ticks;
  logic [TW-1:0] load_width;

  // Clamp in 32-bit arithmetic so large commands can never wrap the width.
  assign pend_ext   = {21'd0, pend_val_q};
  assign add_ticks  = (pend_ext >= 32'(RANGE_TICKS)) ? 32'(RANGE_TICKS) : pend_ext;
  assign load_width = TW'(32'(MIN_TICKS) + add_ticks);

  // Next-state logic: prescaler, frame sequencing, frame load and pending capture.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    tick_cnt_d    = tick_cnt_q;
    width_d       = width_q;
    stale_cnt_d   = stale_cnt_q;
    stale_d       = stale_q;
    pend_flag_d   = pend_flag_q;
    pend_val_d    = pend_val_q;
    frame_load    = 1'b0;
    tick          = (state_q != S_IDLE) && (presc_q == PRESC_LAST);

    if (state_q != S_IDLE) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        presc_d    = '0;
        tick_cnt_d = '0;
        if (enable) begin
          state_d    = S_HIGH;
          frame_load = 1'b1;
        end
      end
      S_HIGH: begin
        if (tick && (tick_cnt_q == width_q - TW'(1))) begin
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        // enable is only looked at here, so a pulse is never cut short.
        if (tick && (tick_cnt_q == FRAME_LAST)) begin
          tick_cnt_d = '0;
          if (enable) begin
            state_d    = S_HIGH;
            frame_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (frame_load) begin
      if (pend_flag_q) begin
        width_d     = load_width;
        pend_flag_d = 1'b0;
        stale_cnt_d = '0;
        stale_d     = 1'b0;
      end else begin
        if (stale_cnt_q != STALE_MAX) begin
          stale_cnt_d = stale_cnt_q + SW'(1);
        end
        if (stale_cnt_d == STALE_MAX) begin
          width_d = MIN_W;
          stale_d = 1'b1;
        end
      end
    end

    // A strobe coincident with a load lands here after the load consumed the
    // old value, so it takes effect one frame later.
    if (command_valid) begin
      pend_flag_d = 1'b1;
      pend_val_d  = command;
    end

    pwm_d         = (state_d == S_HIGH);
    frame_start_d = frame_load;
  end

  // State and registered outputs; reset puts the block straight into failsafe.
  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      tick_cnt_q    <= '0;
      width_q       <= MIN_W;
      stale_cnt_q   <= STALE_MAX;
      stale_q       <= 1'b1;
      pend_flag_q   <= 1'b0;
      pend_val_q    <= '0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      tick_cnt_q    <= tick_cnt_d;
      width_q       <= width_d;
      stale_cnt_q   <= stale_cnt_d;
      stale_q       <= stale_d;
      pend_flag_q   <= pend_flag_d;
      pend_val_q    <= pend_val_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_esc_pulse_generator.sv
// Testbench for esc_pulse_generator: frame-level reference model feeding a
// scoreboard queue; a monitor measures each frame's pulse and compares.
module tb_esc_pulse_generator;

  localparam int CLK_DIV      = 2;
  localparam int MIN_TICKS    = 4;
  localparam int RANGE_TICKS  = 8;
  localparam int FRAME_TICKS  = 32;
  localparam int STALE_FRAMES = 2;
  localparam int FRAME_CYC    = FRAME_TICKS * CLK_DIV;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [10:0] command;
  logic        command_valid;
  logic        pwm_out;
  logic        frame_start;
  logic        stale;

  esc_pulse_generator #(
    .CLK_DIV(CLK_DIV), .MIN_TICKS(MIN_TICKS), .RANGE_TICKS(RANGE_TICKS),
    .FRAME_TICKS(FRAME_TICKS), .STALE_FRAMES(STALE_FRAMES)
  ) dut (
    .clk_system(clk), .reset_n(reset_n), .enable(enable), .command(command),
    .command_valid(command_valid), .pwm_out(pwm_out), .frame_start(frame_start),
    .stale(stale)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int hi_cycles;
    bit stale;
    bit cont;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, per the frame-load rules.
  int m_width;
  int m_cnt;
  bit m_stale;
  bit m_pend;
  int m_pval;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_width = MIN_TICKS;
    m_cnt   = STALE_FRAMES;
    m_stale = 1'b1;
    m_pend  = 1'b0;
    m_pval  = 0;
  endfunction

  function automatic void model_load(input bit cont);
    exp_t e;
    if (m_pend) begin
      m_width = MIN_TICKS + ((m_pval < RANGE_TICKS) ? m_pval : RANGE_TICKS);
      m_cnt   = 0;
      m_stale = 1'b0;
      m_pend  = 1'b0;
    end else begin
      if (m_cnt < STALE_FRAMES) m_cnt++;
      if (m_cnt == STALE_FRAMES) begin
        m_width = MIN_TICKS;
        m_stale = 1'b1;
      end
    end
    e.hi_cycles = m_width * CLK_DIV;
    e.stale     = m_stale;
    e.cont      = cont;
    exp_q.push_back(e);
  endfunction

  function automatic int rand_cmd();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 12);
      1:       return $urandom_range(0, 2047);
      2:       return 2047;
      default: return $urandom_range(RANGE_TICKS - 1, RANGE_TICKS + 1);
    endcase
  endfunction

  // One clock cycle of stimulus; a load (if any) happens before the strobe.
  task automatic drive_cycle(input bit strobe, input int val, input bit is_load, input bit cont);
    @(negedge clk);
    if (is_load) model_load(cont);
    command_valid = strobe;
    command       = strobe ? 11'(val) : 11'($urandom);
    if (strobe) begin
      m_pend = 1'b1;
      m_pval = val;
    end
  endtask

  task automatic start_from_idle();
    @(negedge clk);
    enable = 1'b1;
    model_load(1'b0);
    command_valid = 1'b0;
  endtask

  // One 64-cycle frame; j=0 is the frame_start cycle, j=63 carries the next load.
  task automatic run_frame(input int s1, input int v1, input int s2, input int v2,
                           input int drop_at, input int abort_at);
    for (int j = 0; j < FRAME_CYC; j++) begin
      if (j == drop_at) enable = 1'b0;
      drive_cycle((j == s1) || (j == s2), (j == s2) ? v2 : v1,
                  (j == FRAME_CYC - 1) && enable, 1'b1);
      if (j == abort_at) return;
    end
  endtask

  task automatic run_random_frame();
    int s1, s2;
    s1 = -1;
    s2 = -1;
    case ($urandom_range(0, 5))
      0, 1: ;
      2:    s1 = $urandom_range(0, FRAME_CYC - 2);
      3: begin s1 = $urandom_range(0, 30); s2 = $urandom_range(31, FRAME_CYC - 2); end
      4:    s1 = FRAME_CYC - 1;
      default: s1 = 0;
    endcase
    run_frame(s1, rand_cmd(), s2, rand_cmd(), -1, -1);
  endtask

  // Monitor: pops one expectation per frame_start and measures the pulse.
  exp_t cur;
  bit   meas;
  int   hi_cnt;
  int   cyc;
  int   last_fs;
  bit   pwm_prev;

  initial begin
    meas = 0; hi_cnt = 0; cyc = 0; last_fs = -1; pwm_prev = 0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      meas     = 0;
      last_fs  = -1;
      pwm_prev = 0;
    end else begin
      cyc++;
      if (frame_start) begin
        if (meas) check("pulse_overrun", hi_cnt, cur.hi_cycles);
        meas = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("stale_at_frame", int'(stale), int'(cur.stale));
          check("pwm_rise_with_frame", int'(pwm_out), 1);
          if (cur.cont && last_fs >= 0) check("frame_period", cyc - last_fs, FRAME_CYC);
          last_fs = cyc;
          meas    = 1;
          hi_cnt  = 0;
        end
      end else if (pwm_out && !pwm_prev) begin
        check("rise_without_frame", 1, 0);
      end
      if (meas) begin
        if (pwm_out) hi_cnt++;
        else begin
          check("pulse_width", hi_cnt, cur.hi_cycles);
          meas = 0;
        end
      end
      pwm_prev = pwm_out;
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; command = '0; command_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_stale", int'(stale), 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pwm", int'(pwm_out), 0);

    // Failsafe from reset: minimum pulses, stale held.
    start_from_idle();
    repeat (3) run_frame(-1, 0, -1, 0, -1, -1);

    // Nominal, hold, then stale timeout.
    run_frame(10, 3, -1, 0, -1, -1);
    repeat (3) run_frame(-1, 0, -1, 0, -1, -1);

    // Clamp with last-write-wins, then zero command.
    run_frame(5, 20, 30, 2047, -1, -1);
    run_frame(5, 0, -1, 0, -1, -1);

    // Strobe on the frame_start cycle and on the load cycle.
    run_frame(0, 1, 63, 9, -1, -1);
    run_frame(-1, 0, -1, 0, -1, -1);
    run_frame(10, 5, -1, 0, -1, -1);
    repeat (3) run_frame(-1, 0, -1, 0, -1, -1);
    run_frame(20, 5, -1, 0, -1, -1);
    run_frame(-1, 0, -1, 0, -1, -1);

    // Randomized frames.
    repeat (40) run_random_frame();

    // enable dropped mid-HIGH: pulse and frame complete, then idle.
    run_frame(-1, 0, -1, 0, 2, -1);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(i == 4, 6, 1'b0, 1'b0);
      check("idle_after_drop_pwm", int'(pwm_out), 0);
      check("idle_after_drop_fs", int'(frame_start), 0);
    end
    start_from_idle();
    repeat (2) run_frame(-1, 0, -1, 0, -1, -1);

    // Reset during HIGH.
    run_frame(-1, 0, -1, 0, -1, 3);
    command_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_stale", int'(stale), 1);
    check("async_reset_fs", int'(frame_start), 0);
    model_reset();
    exp_q.delete();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    start_from_idle();
    repeat (2) run_frame(-1, 0, -1, 0, -1, -1);

    // Wind down and drain.
    run_frame(-1, 0, -1, 0, 5, -1);
    repeat (FRAME_CYC) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("measure_done", int'(meas), 0);
    check("final_pwm_idle", int'(pwm_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/esc_pulse_generator.md
# esc_pulse_generator

Generates the 50 Hz servo/ESC pulse stream for one motor channel from an 11-bit throttle command. It is the transmit counterpart of the receiver-channel pulse measurer: the command is in the same count domain as a measured channel, and the output drives an ESC directly. It sits between the flight-control mixer and the motor pins, one instance per motor. A built-in failsafe drops to minimum pulse width when commands stop arriving.

## Interface
- CLK_DIV, 50: clk_system cycles per tick (50 MHz gives a 1 us tick).
- MIN_TICKS, 1000: pulse width, in ticks, for command 0 (1 ms).
- RANGE_TICKS, 1000: maximum added width; larger commands are clamped.
- FRAME_TICKS, 20000: frame period in ticks (20 ms); must exceed MIN_TICKS+RANGE_TICKS.
- STALE_FRAMES, 3: consecutive frames without a new command before failsafe.

- clk_system  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run the pulse stream.
- command  in  11  throttle value, unsigned.
- command_valid  in  1  one-cycle strobe qualifying command.
- pwm_out  out  1  ESC pulse, registered.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- stale  out  1  failsafe active.

## Operation
- **Pending register:** command_valid writes command to the pending register and sets the pending flag. A later strobe before the next frame load overwrites it (last write wins).
- **Prescaler:** counts 0..CLK_DIV-1 only outside IDLE; tick is asserted at CLK_DIV-1. Tick counter width is clog2(FRAME_TICKS).
- **State machine:** IDLE, HIGH, LOW.
  - IDLE → HIGH when enable=1. Clears the prescaler and tick counter and performs a frame load.
  - HIGH → LOW on the tick where tick count = width-1.
  - LOW → HIGH (new frame, frame load) on the tick where tick count = FRAME_TICKS-1, if enable=1. Otherwise LOW → IDLE.
  - enable is sampled only at frame end, so no runt pulses are produced.
- **Frame load:**
  - If the pending flag is set: width = MIN_TICKS + min(pending, RANGE_TICKS); clear the pending flag, the stale counter and stale.
  - If the pending flag is clear: increment the stale counter, saturating at STALE_FRAMES.
    - If the counter now equals STALE_FRAMES: width = MIN_TICKS and stale=1.
    - Otherwise: keep the previous width.
- **Same-cycle strobe:** a command_valid in the same cycle as a frame load goes to pending and takes effect at the following frame.
- **Reset values:**
  - Outputs: pwm_out=0, frame_start=0, stale=1.
  - Internal: state IDLE, width=MIN_TICKS, stale counter=STALE_FRAMES, pending flag=0, pending register=0. The block starts in failsafe.

## Timing
- pwm_out is registered and is high exactly while state=HIGH.
  - High time = width×CLK_DIV cycles.
  - Frame = FRAME_TICKS×CLK_DIV cycles, with no gap cycles between frames.
- Latency from enable=1 in IDLE to pwm_out=1 is 1 cycle. frame_start rises in the same cycle as pwm_out.
- stale updates in the same cycle as the frame load that changes it, i.e. coincident with frame_start.
- reset_n low at any time forces pwm_out=0 and the IDLE state immediately (asynchronous). After release, a new frame starts 1 cycle after enable is sampled high.
- Clamp rule: commands from RANGE_TICKS to 2047 all give width MIN_TICKS+RANGE_TICKS. Width arithmetic must not wrap.

## Test plan
All scenarios use parameters CLK_DIV=2, MIN_TICKS=4, RANGE_TICKS=8, FRAME_TICKS=32, STALE_FRAMES=2.

- **Reset/failsafe:** enable=1 after reset with no command → stale=1, pwm_out high 8 cycles per 64-cycle frame, frame_start every 64 cycles.
- **Nominal:** command=3 strobed, then 2 frames → the next frame has a 14-cycle pulse, stale=0 at that frame_start. The frame after it also has a 14-cycle pulse (held).
- **Clamp and last-write-wins:** strobe command=20, then command=2047, within one frame → next pulse 24 cycles. Strobe command=0 → next pulse 8 cycles.
- **Stale timeout:** command=5 loaded, then no strobes → frame N 18 cycles, frame N+1 18 cycles, frame N+2 8 cycles with stale=1. A strobe of 5 restores 18 cycles and stale=0 at the next load.
- **Simultaneous and enable:**
  - command_valid coincident with frame_start → value appears one frame later.
  - enable dropped mid-HIGH → full pulse completes, the frame completes, then IDLE with pwm_out=0.
- **Reset mid-pulse:** assert reset_n=0 during HIGH → pwm_out=0 within the same cycle, stale=1. After re-enable, the first pulse is 8 cycles.
